mutative_tag_sram: RTL and testbench

Parametrised, synthesizable single-port tag store for the mutative cache. It replaces the fixed 128×20 behavioural tag macro model with a configurable width, depth and write-mask granularity. It adds a synchronous reset that sweeps every entry to a known value before accepting traffic, and a ready/valid indication toward the cache controller. It sits between the cache controller's tag-lookup stage and the tag storage.

---
 rtl/mutative_tag_sram.sv | 86 ++++++++
 tb/tb_mutative_tag_sram.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mutative_tag_sram.sv
// Single-port tag store for the mutative cache: masked writes, registered read data, ready/valid.
// Define MUTATIVE_TAG_SRAM_INIT_EN to sweep INIT_VALUE into every entry after reset.
module mutative_tag_sram #(
  parameter int                    DATA_WIDTH  = 20,
  parameter int                    ADDR_WIDTH  = 7,
  parameter int                    WMASK_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk0,
  input  logic                   rstb0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   rvalid0,
  output logic                   ready0
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  // INIT_VALUE is declared DATA_WIDTH wide, so this is DATA_WIDTH / WMASK_WIDTH.
  localparam int GROUP_WIDTH = $bits(INIT_VALUE) / WMASK_WIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  rd_req;
  logic                  wr_req;
`ifdef MUTATIVE_TAG_SRAM_INIT_EN
  logic [ADDR_WIDTH-1:0] sweep_cnt;
`endif

  // ready0 is a decode of a single state flop, so it is glitch-free.
  assign ready0 = (state == ST_READY);
  assign rd_req = ready0 && !csb0 && web0;
  assign wr_req = ready0 && !csb0 && !web0;

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      state   <= ST_INIT;
      rvalid0 <= 1'b0;
      dout0   <= '0;
`ifdef MUTATIVE_TAG_SRAM_INIT_EN
      sweep_cnt <= '0;
`endif
    end else begin
      rvalid0 <= rd_req;
      if (rd_req) begin
        dout0 <= mem[addr0];
      end
      if (state == ST_INIT) begin
`ifdef MUTATIVE_TAG_SRAM_INIT_EN
        sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
        if (&sweep_cnt) begin
          state <= ST_READY;
        end
`else
        state <= ST_READY;
`endif
      end
    end
  end

  // NOTE: mem is deliberately kept out of reset so it maps onto a RAM macro; known contents
  // come from the init sweep instead, and no write happens while rstb0 is low.
  always_ff @(posedge clk0) begin
    if (rstb0) begin
`ifdef MUTATIVE_TAG_SRAM_INIT_EN
      if (state == ST_INIT) begin
        mem[sweep_cnt] <= INIT_VALUE;
      end
`endif
      if (wr_req) begin
        for (int i = 0; i < WMASK_WIDTH; i++) begin
          if (wmask0[i]) begin
            mem[addr0][i*GROUP_WIDTH +: GROUP_WIDTH] <= din0[i*GROUP_WIDTH +: GROUP_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mutative_tag_sram.sv
// Self-checking bench for mutative_tag_sram (WMASK_WIDTH=4); honours MUTATIVE_TAG_SRAM_INIT_EN.
module tb_mutative_tag_sram;

  localparam int DW    = 20;
  localparam int AW    = 7;
  localparam int MW    = 4;
  localparam int G     = DW / MW;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] INIT_VAL = 20'h00000;
`ifdef MUTATIVE_TAG_SRAM_INIT_EN
  localparam int LAT       = DEPTH;
  localparam int DROP_EDGE = 10;
`else
  localparam int LAT       = 1;
  localparam int DROP_EDGE = 1;
`endif

  logic          clk0 = 1'b0;
  logic          rstb0;
  logic          csb0;
  logic          web0;
  logic [MW-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;
  logic          rvalid0;
  logic          ready0;

  mutative_tag_sram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WMASK_WIDTH(MW),
    .INIT_VALUE (INIT_VAL)
  ) dut (
    .clk0   (clk0),
    .rstb0  (rstb0),
    .csb0   (csb0),
    .web0   (web0),
    .wmask0 (wmask0),
    .addr0  (addr0),
    .din0   (din0),
    .dout0  (dout0),
    .rvalid0(rvalid0),
    .ready0 (ready0)
  );

  always #5 clk0 = ~clk0;

  int total = 0;
  int bad   = 0;

  // Reference model: word contents plus a per-bit "known" mask for never-written bits.
  logic [DW-1:0] m_mem   [DEPTH];
  logic [DW-1:0] m_known [DEPTH];
  logic          m_ready;
  logic          m_rvalid;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_dknown;

  typedef struct {
    logic          cs;
    logic          we;
    logic [MW-1:0] mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          rv;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  function automatic logic [DW-1:0] expand(input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int g = 0; g < MW; g++) begin
      if (m[g]) r = r | (((DW'(1) << G) - DW'(1)) << (g * G));
    end
    return r;
  endfunction

  task automatic step(input logic cs, input logic we, input logic [MW-1:0] m,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] bm;
    csb0 = cs; web0 = we; wmask0 = m; addr0 = a; din0 = d;
    tick();
    m_rvalid = 1'b0;
    if (m_ready && !cs) begin
      if (we) begin
        m_dout   = m_mem[a];
        m_dknown = m_known[a];
        m_rvalid = 1'b1;
      end else begin
        bm         = expand(m);
        m_mem[a]   = (m_mem[a] & ~bm) | (d & bm);
        m_known[a] = m_known[a] | bm;
      end
    end
    check("rvalid", 32'(rvalid0), 32'(m_rvalid));
    check("dout", 32'(dout0 & m_dknown), 32'(m_dout & m_dknown));
    check("ready", 32'(ready0), 32'(m_ready));
    csb0 = 1'b1;
  endtask

  task automatic apply_reset(input int cycles, input logic with_req);
    rstb0 = 1'b0;
    csb0 = with_req ? 1'b0 : 1'b1;
    web0 = 1'b0; wmask0 = '1; addr0 = AW'(5); din0 = 20'hABCDE;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check("rst_ready", 32'(ready0), 32'd0);
      check("rst_rvalid", 32'(rvalid0), 32'd0);
      check("rst_dout", 32'(dout0), 32'd0);
    end
    m_ready = 1'b0; m_rvalid = 1'b0; m_dout = '0; m_dknown = '1;
    rstb0 = 1'b1;
    csb0  = 1'b1;
  endtask

  // Clocks until ready0 rises; optionally issues a write that must be dropped.
  task automatic sweep(input int drop_edge, input int expect_edges);
    int edges;
    edges = 0;
    while (ready0 !== 1'b1 && edges < 4 * DEPTH) begin
      if (edges + 1 == drop_edge) begin
        csb0 = 1'b0; web0 = 1'b0; wmask0 = '1; addr0 = AW'(5); din0 = 20'hABCDE;
      end else begin
        csb0 = 1'b1;
      end
      tick();
      edges++;
      check("sweep_rvalid", 32'(rvalid0), 32'd0);
    end
    csb0 = 1'b1;
    check("init_latency", 32'(edges), 32'(expect_edges));
    m_ready = 1'b1;
`ifdef MUTATIVE_TAG_SRAM_INIT_EN
    for (int a = 0; a < DEPTH; a++) begin
      m_mem[a]   = INIT_VAL;
      m_known[a] = '1;
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int run;
    logic [DW-1:0] exp_drop;

    rstb0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    for (int a = 0; a < DEPTH; a++) begin
      m_mem[a]   = '0;
      m_known[a] = '0;
    end

    // Mask 4'b0101 clears groups 0 and 2 of 20'hFFFFF -> 20'hF83E0.
    // Mask 4'b1010 merges 20'hABCDE groups 1,3 into 20'h12345 -> 20'hAA0C5.
    vecs[0]  = '{1'b0, 1'b0, 4'hF, 7'd3,   20'hFFFFF, 1'b0, 20'h00000};
    vecs[1]  = '{1'b0, 1'b0, 4'h5, 7'd3,   20'h00000, 1'b0, 20'h00000};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 7'd3,   20'h00000, 1'b1, 20'hF83E0};
    vecs[3]  = '{1'b1, 1'b1, 4'h0, 7'd3,   20'h00000, 1'b0, 20'hF83E0};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 7'd3,   20'h12345, 1'b0, 20'hF83E0};
    vecs[5]  = '{1'b0, 1'b1, 4'h0, 7'd3,   20'h00000, 1'b1, 20'hF83E0};
    vecs[6]  = '{1'b0, 1'b0, 4'hF, 7'd127, 20'h12345, 1'b0, 20'hF83E0};
    vecs[7]  = '{1'b0, 1'b1, 4'h0, 7'd127, 20'h00000, 1'b1, 20'h12345};
    vecs[8]  = '{1'b0, 1'b0, 4'hA, 7'd127, 20'hABCDE, 1'b0, 20'h12345};
    vecs[9]  = '{1'b0, 1'b1, 4'h0, 7'd127, 20'h00000, 1'b1, 20'hAA0C5};
    vecs[10] = '{1'b1, 1'b0, 4'hF, 7'd127, 20'h00000, 1'b0, 20'hAA0C5};

    apply_reset(3, 1'b0);
    sweep(0, LAT);

`ifdef MUTATIVE_TAG_SRAM_INIT_EN
    step(1'b0, 1'b1, '0, AW'(0), '0);   check("init_word0",   32'(dout0), 32'(INIT_VAL));
    step(1'b0, 1'b1, '0, AW'(64), '0);  check("init_word64",  32'(dout0), 32'(INIT_VAL));
    step(1'b0, 1'b1, '0, AW'(127), '0); check("init_word127", 32'(dout0), 32'(INIT_VAL));
`endif

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].cs, vecs[i].we, vecs[i].mask, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid0), 32'(vecs[i].rv));
      check($sformatf("vec%0d_dout", i), 32'(dout0), 32'(vecs[i].dout));
    end

    // Streaming reads: one per cycle, rvalid0 high for the whole burst.
    for (int n = 0; n < 8; n++) step(1'b0, 1'b0, '1, AW'(n), DW'(32'h10000 + n));
    run = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b1, '0, AW'(n), '0);
      check("stream_dout", 32'(dout0), 32'h10000 + n);
      if (rvalid0 === 1'b1) run++;
    end
    check("stream_run", 32'(run), 32'd8);
    step(1'b1, 1'b1, '0, '0, '0);
    check("stream_end", 32'(rvalid0), 32'd0);

    // Requests during reset and before ready0 must be dropped.
    step(1'b0, 1'b0, '1, AW'(5), 20'h11111);
    step(1'b0, 1'b1, '0, AW'(5), '0);
    check("pre_drop_word", 32'(dout0), 32'h11111);
    apply_reset(3, 1'b1);
    sweep(DROP_EDGE, LAT);
    step(1'b0, 1'b1, '0, AW'(5), '0);
`ifdef MUTATIVE_TAG_SRAM_INIT_EN
    exp_drop = INIT_VAL;
`else
    exp_drop = 20'h11111;
`endif
    check("drop_word", 32'(dout0), 32'(exp_drop));
    check("drop_rvalid", 32'(rvalid0), 32'd1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), MW'($urandom),
           AW'($urandom_range(0, 15)), DW'($urandom));
    end

`ifdef MUTATIVE_TAG_SRAM_INIT_EN
    // Reset at sweep edge 60 restarts the full sweep.
    apply_reset(3, 1'b0);
    for (int i = 0; i < 60; i++) begin
      tick();
      check("mid_ready", 32'(ready0), 32'd0);
    end
    apply_reset(2, 1'b0);
    sweep(0, DEPTH);
    step(1'b0, 1'b1, '0, AW'(3), '0);
    check("mid_word", 32'(dout0), 32'(INIT_VAL));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
